// File: rtl/scr_stack_pkg.sv
// Shared types and default widths for the scratch-RAM stack controller.
package scr_stack_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_REG_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RET  = 2'd2
  } state_t;

  typedef enum logic {
    TGT_REG = 1'b0,
    TGT_PC  = 1'b1
  } tgt_t;

endpackage

// File: rtl/scr_stack_occ.sv
// Stack occupancy tracker and sticky overflow/underflow/misuse flag.
// Only instantiated when SCR_STACK_CHK_EN is defined.
module scr_stack_occ
  import scr_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_sp_ld,
  input  logic [ADDR_W-1:0] i_sp_din,
  input  logic              i_req_busy,
  output logic              o_stk_err
);

  localparam logic [ADDR_W:0] OCC_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] OCC_ZERO = '0;

  logic [ADDR_W:0] r_occ;
  logic            r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_occ <= OCC_ZERO;
      r_err <= 1'b0;
    end else begin
      // Depth implied by a loaded SP: the stack is empty at SP=0 and grows down.
      if (i_sp_ld)
        r_occ <= {1'b0, {ADDR_W{1'b0}} - i_sp_din};
      else if (i_push)
        r_occ <= r_occ + OCC_ONE;
      else if (i_pop)
        r_occ <= r_occ - OCC_ONE;

      if ((i_push && r_occ == OCC_FULL) || (i_pop && r_occ == OCC_ZERO) || i_req_busy)
        r_err <= 1'b1;
    end
  end

  assign o_stk_err = r_err;

endmodule

// File: rtl/scr_stack_ctrl.sv
// Scratch-RAM stack controller: SP ownership, push writes, pop read sequencing.
// Optional depth checking is enabled by defining SCR_STACK_CHK_EN.
module scr_stack_ctrl
  import scr_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP_REG,
  input  logic              POP_PC,
  input  logic              SP_LD,
  input  logic [ADDR_W-1:0] SP_DIN,
  input  logic [DATA_W-1:0] SCR_DOUT,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [ADDR_W-1:0] SP_OUT,
  output logic [REG_W-1:0]  REG_DATA,
  output logic              REG_VALID,
  output logic [DATA_W-1:0] PC_DATA,
  output logic              PC_VALID,
  output logic              BUSY,
  output logic              STK_ERR
);

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  tgt_t              r_tgt;
  tgt_t              w_pop_tgt;
  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_addr;
  logic [REG_W-1:0]  r_reg_data;
  logic [DATA_W-1:0] r_pc_data;
  logic              w_idle;
  logic              w_sp_ld;
  logic              w_push;
  logic              w_pop;

  // Accepted requests after priority resolution; RST masks them so no write escapes.
  assign w_idle    = (r_state == IDLE);
  assign w_sp_ld   = w_idle && !RST && SP_LD;
  assign w_push    = w_idle && !RST && !SP_LD && PUSH;
  assign w_pop     = w_idle && !RST && !SP_LD && !PUSH && (POP_PC || POP_REG);
  assign w_pop_tgt = POP_PC ? TGT_PC : TGT_REG;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_next = RD;
      RD:      w_state_next = RET;
      RET:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    SCR_ADDR  = r_sp;
    SCR_WE    = 1'b0;
    BUSY      = 1'b0;
    REG_VALID = 1'b0;
    PC_VALID  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_push) begin
          SCR_ADDR = r_sp - SP_ONE;
          SCR_WE   = 1'b1;
        end
      end
      RD: begin
        SCR_ADDR = r_addr;
        BUSY     = 1'b1;
      end
      RET: begin
        SCR_ADDR  = r_addr;
        BUSY      = 1'b1;
        REG_VALID = (r_tgt == TGT_REG);
        PC_VALID  = (r_tgt == TGT_PC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sp       <= '0;
      r_addr     <= '0;
      r_tgt      <= TGT_REG;
      r_reg_data <= '0;
      r_pc_data  <= '0;
    end else begin
      if (w_sp_ld)
        r_sp <= SP_DIN;
      else if (w_push)
        r_sp <= r_sp - SP_ONE;
      else if (r_state == RD)
        r_sp <= r_sp + SP_ONE;

      if (w_pop) begin
        r_addr <= r_sp;
        r_tgt  <= w_pop_tgt;
      end

      if (r_state == RD) begin
        r_reg_data <= SCR_DOUT[REG_W-1:0];
        r_pc_data  <= SCR_DOUT;
      end
    end
  end

  assign SP_OUT   = r_sp;
  assign REG_DATA = r_reg_data;
  assign PC_DATA  = r_pc_data;

`ifdef SCR_STACK_CHK_EN
  logic w_req_busy;
  logic w_stk_err;

  assign w_req_busy = !w_idle && (PUSH || POP_REG || POP_PC || SP_LD);

  scr_stack_occ #(
    .ADDR_W(ADDR_W)
  ) u_occ (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_sp_ld   (w_sp_ld),
    .i_sp_din  (SP_DIN),
    .i_req_busy(w_req_busy),
    .o_stk_err (w_stk_err)
  );

  assign STK_ERR = w_stk_err;
`else
  assign STK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Directed bench for scr_stack_ctrl with a behavioural synchronous-read scratch RAM.
module tb_scr_stack_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop_reg;
  logic       pop_pc;
  logic       sp_ld;
  logic [7:0] sp_din;
  logic [9:0] scr_dout;
  logic [9:0] scr_din;
  logic [7:0] scr_addr;
  logic       scr_we;
  logic [7:0] sp_out;
  logic [7:0] reg_data;
  logic       reg_valid;
  logic [9:0] pc_data;
  logic       pc_valid;
  logic       busy;
  logic       stk_err;

  int errors = 0;
  int checks = 0;
  logic exp_err;

  logic [9:0] mem [256];

  scr_stack_ctrl dut (
    .CLK      (clk),
    .RST      (rst),
    .PUSH     (push),
    .POP_REG  (pop_reg),
    .POP_PC   (pop_pc),
    .SP_LD    (sp_ld),
    .SP_DIN   (sp_din),
    .SCR_DOUT (scr_dout),
    .SCR_ADDR (scr_addr),
    .SCR_WE   (scr_we),
    .SP_OUT   (sp_out),
    .REG_DATA (reg_data),
    .REG_VALID(reg_valid),
    .PC_DATA  (pc_data),
    .PC_VALID (pc_valid),
    .BUSY     (busy),
    .STK_ERR  (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (scr_we) mem[scr_addr] <= scr_din;
    scr_dout <= mem[scr_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1; push = 0; pop_reg = 0; pop_pc = 0; sp_ld = 0; sp_din = '0; scr_din = '0;
`ifdef SCR_STACK_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_sp",       32'(sp_out),    32'h00);
    check("rst_addr",     32'(scr_addr),  32'h00);
    check("rst_we",       32'(scr_we),    32'h0);
    check("rst_reg_data", 32'(reg_data),  32'h00);
    check("rst_pc_data",  32'(pc_data),   32'h000);
    check("rst_valids",   32'({reg_valid, pc_valid}), 32'h0);
    check("rst_busy",     32'(busy),      32'h0);
    check("rst_stk_err",  32'(stk_err),   32'h0);

    // Push at SP=0 wraps to the top address.
    tick();
    scr_din = 10'h2A5; push = 1'b1;
    #1;
    check("push_addr", 32'(scr_addr), 32'hFF);
    check("push_we",   32'(scr_we),   32'h1);
    tick();
    push = 1'b0;
    check("push_sp", 32'(sp_out), 32'hFF);

    // POP_PC: strobe two cycles after the request.
    pop_pc = 1'b1;
    #1;
    check("pop_pc_addr", 32'(scr_addr), 32'hFF);
    tick();
    pop_pc = 1'b0;
    check("pop_pc_busy1",  32'(busy),     32'h1);
    check("pop_pc_valid1", 32'(pc_valid), 32'h0);
    check("pop_pc_we_rd",  32'(scr_we),   32'h0);
    tick();
    check("pop_pc_busy2",  32'(busy),     32'h1);
    check("pop_pc_valid2", 32'(pc_valid), 32'h1);
    check("pop_pc_data",   32'(pc_data),  32'h2A5);
    check("pop_pc_sp",     32'(sp_out),   32'h00);
    tick();
    check("pop_pc_busy3",  32'(busy),     32'h0);
    check("pop_pc_valid3", 32'(pc_valid), 32'h0);

    // SP_LD, push, POP_REG returns low slice.
    sp_ld = 1'b1; sp_din = 8'h80;
    tick();
    sp_ld = 1'b0;
    check("ld_sp", 32'(sp_out), 32'h80);
    scr_din = 10'h1C3; push = 1'b1;
    #1;
    check("push2_addr", 32'(scr_addr), 32'h7F);
    tick();
    push = 1'b0;
    check("push2_sp", 32'(sp_out), 32'h7F);
    pop_reg = 1'b1;
    tick();
    pop_reg = 1'b0;
    tick();
    check("pop_reg_valid",    32'(reg_valid), 32'h1);
    check("pop_reg_pc_valid", 32'(pc_valid),  32'h0);
    check("pop_reg_data",     32'(reg_data),  32'hC3);
    tick();
    check("pop_reg_sp",     32'(sp_out),    32'h80);
    check("pop_reg_valid3", 32'(reg_valid), 32'h0);

    // PUSH beats POP_REG in the same cycle.
    scr_din = 10'h055; push = 1'b1; pop_reg = 1'b1;
    tick();
    push = 1'b0; pop_reg = 1'b0;
    check("prio_sp",   32'(sp_out), 32'h7F);
    check("prio_busy", 32'(busy),   32'h0);
    tick();
    check("prio_no_strobe", 32'({reg_valid, pc_valid}), 32'h0);

    // POP_PC held through RD: the extra request is ignored.
    pop_pc = 1'b1;
    tick();
    tick();
    pop_pc = 1'b0;
    check("busy_ign_valid", 32'(pc_valid), 32'h1);
    check("busy_ign_data",  32'(pc_data),  32'h055);
    tick();
    check("busy_ign_valid2", 32'(pc_valid), 32'h0);
    check("busy_ign_busy2",  32'(busy),     32'h0);
    tick();
    check("busy_ign_valid3", 32'(pc_valid), 32'h0);
    check("busy_ign_sp",     32'(sp_out),   32'h80);

    // RST during RD aborts the pop.
    pop_reg = 1'b1;
    tick();
    pop_reg = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_sp",    32'(sp_out),    32'h00);
    check("abort_busy",  32'(busy),      32'h0);
    check("abort_valid", 32'(reg_valid), 32'h0);
    tick();
    check("abort_valid2", 32'(reg_valid), 32'h0);

    // Underflow: POP_REG straight after reset.
    pop_reg = 1'b1;
    tick();
    pop_reg = 1'b0;
    check("uflow_err1", 32'(stk_err), 32'(exp_err));
    tick(); tick();
    check("uflow_sp",   32'(sp_out),  32'h01);
    check("uflow_err2", 32'(stk_err), 32'(exp_err));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("uflow_err_rst", 32'(stk_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
